// File: rtl/uop_pkg.sv
// rtl/uop_pkg.sv - shared parameters, entry layout and FSM states for the uop buffer
//
// Purpose: buffer geometry, the NOP filler word, entry field offsets and the
// packed entry struct used by both the fill (write) side and the fetch (read)
// side of the micro-op buffer.
// Ports: none (package).
package uop_pkg;

   localparam int MAX_PREDICT_DEPTH_BITS = 2;
   localparam int UOP_BUF_SIZE           = 16;
   localparam int UOP_BUF_WIDTH          = 64 + 2 * MAX_PREDICT_DEPTH_BITS;

   localparam int UOP_PTR_W = $clog2(UOP_BUF_SIZE);
   localparam int UOP_CNT_W = UOP_PTR_W + 1;

   localparam logic [31:0] UOP_NOP = 32'h0000_0000;

   // Field offsets inside one buffer entry.
   localparam int UOP_INSTR1_LSB = 0;
   localparam int UOP_INSTR2_LSB = 32;
   localparam int UOP_TAG2_LSB   = 64;
   localparam int UOP_TAG1_LSB   = 64 + MAX_PREDICT_DEPTH_BITS;

   // Declaration order gives tag1 the MSBs and instr1 the LSBs.
   typedef struct packed {
      logic [MAX_PREDICT_DEPTH_BITS-1:0] tag1;
      logic [MAX_PREDICT_DEPTH_BITS-1:0] tag2;
      logic [31:0]                       instr2;
      logic [31:0]                       instr1;
   } uop_entry_t;

   typedef enum logic {
      FILL_EMPTY = 1'b0,
      FILL_HALF  = 1'b1
   } fill_state_t;

endpackage

// File: rtl/uop_fill_occupancy.sv
// rtl/uop_fill_occupancy.sv - entry occupancy counter for the uop buffer
//
// Purpose: counts entries written and not yet popped, and derives the
// fill-side ready and the reader-side nonempty flag from it.
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   clear         flush: count returns to 0
//   inc           an entry is being written on this edge (registered buf_we)
//   dec           reader consumed one entry on this edge
//   count         entries written and not popped
//   in_ready      room for another beat (ignores a same-cycle pop)
//   nonempty      count != 0
module uop_occupancy
   import uop_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear,
   input  logic                 inc,
   input  logic                 dec,
   output logic [UOP_CNT_W-1:0] count,
   output logic                 in_ready,
   output logic                 nonempty
);

   logic dec_ok;

   // A pop with nothing buffered is ignored rather than wrapping the count.
   assign dec_ok = dec && (count != '0);

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (inc && !dec_ok) begin
         count <= count + UOP_CNT_W'(1);
      end else if (!inc && dec_ok) begin
         count <= count - UOP_CNT_W'(1);
      end
   end

   // The in-flight write is counted so a beat is never accepted into a slot
   // that the pending write is about to fill.
   assign in_ready = (count + UOP_CNT_W'(inc)) < UOP_CNT_W'(UOP_BUF_SIZE);
   assign nonempty = (count != '0);

endmodule

// File: rtl/uop_fill.sv
// rtl/uop_fill.sv - pairs decoded instructions into uop buffer entries
//
// Purpose: accepts one instruction per beat, packs two per entry (or one plus
// a NOP when a group ends early), writes entries at a wrapping address and
// tracks occupancy for the fetch-side reader.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   clear                   flush: drop held/buffered uops, wptr to 0
//   in_valid/in_ready       decode handshake
//   in_instr, in_tag        instruction word and its branch tag
//   in_last                 last instruction of a group
//   rd_pop                  reader consumed one entry
//   buf_we/buf_waddr/buf_wdata  registered buffer RAM write port
//   count, nonempty         occupancy seen by the reader
module uop_fill
   import uop_pkg::*;
(
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              clear,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [31:0]                       in_instr,
   input  logic [MAX_PREDICT_DEPTH_BITS-1:0] in_tag,
   input  logic                              in_last,
   input  logic                              rd_pop,
   output logic                              buf_we,
   output logic [UOP_PTR_W-1:0]              buf_waddr,
   output logic [UOP_BUF_WIDTH-1:0]          buf_wdata,
   output logic [UOP_CNT_W-1:0]              count,
   output logic                              nonempty
);

   fill_state_t                       state;
   fill_state_t                       state_next;
   logic [31:0]                       hold_instr;
   logic [MAX_PREDICT_DEPTH_BITS-1:0] hold_tag;
   logic [UOP_PTR_W-1:0]              wptr;
   logic                              accept;
   logic                              emit;
   logic                              capture_hold;
   uop_entry_t                        entry_next;

   uop_occupancy u_occupancy (
      .clk      (clk),
      .reset    (reset),
      .clear    (clear),
      .inc      (buf_we),
      .dec      (rd_pop),
      .count    (count),
      .in_ready (in_ready),
      .nonempty (nonempty)
   );

   assign accept = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= FILL_EMPTY;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next   = state;
      emit         = 1'b0;
      capture_hold = 1'b0;
      entry_next   = '0;
      if (accept) begin
         case (state)
            FILL_EMPTY: begin
               if (in_last) begin
                  // Group ends on an odd instruction: pad slot 2 with a NOP.
                  emit              = 1'b1;
                  entry_next.tag1   = in_tag;
                  entry_next.instr2 = UOP_NOP;
                  entry_next.instr1 = in_instr;
               end else begin
                  capture_hold = 1'b1;
                  state_next   = FILL_HALF;
               end
            end
            FILL_HALF: begin
               emit              = 1'b1;
               entry_next.tag1   = hold_tag;
               entry_next.tag2   = in_tag;
               entry_next.instr2 = in_instr;
               entry_next.instr1 = hold_instr;
               state_next        = FILL_EMPTY;
            end
            default: state_next = FILL_EMPTY;
         endcase
      end
      // Flush beats any beat presented in the same cycle.
      if (reset || clear) begin
         state_next   = FILL_EMPTY;
         emit         = 1'b0;
         capture_hold = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         buf_we     <= 1'b0;
         buf_waddr  <= '0;
         buf_wdata  <= '0;
         wptr       <= '0;
         hold_instr <= '0;
         hold_tag   <= '0;
      end else begin
         buf_we <= emit;
         if (clear) begin
            wptr <= '0;
         end else if (emit) begin
            // Power-of-two size: the natural wrap is the modulo.
            wptr <= wptr + UOP_PTR_W'(1);
         end
         if (emit) begin
            buf_waddr <= wptr;
            buf_wdata <= entry_next;
         end
         if (capture_hold) begin
            hold_instr <= in_instr;
            hold_tag   <= in_tag;
         end
      end
   end

endmodule

// File: tb/tb_uop_fill.sv
// tb/tb_uop_fill.sv - self-checking bench for uop_fill
module tb_uop_fill;
   import uop_pkg::*;

   logic        clk;
   logic        reset;
   logic        clear;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [1:0]  in_tag;
   logic        in_last;
   logic        rd_pop;
   logic        buf_we;
   logic [3:0]  buf_waddr;
   logic [67:0] buf_wdata;
   logic [4:0]  count;
   logic        nonempty;

   int checks = 0;
   int errors = 0;

   uop_fill dut (
      .clk       (clk),
      .reset     (reset),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_instr  (in_instr),
      .in_tag    (in_tag),
      .in_last   (in_last),
      .rd_pop    (rd_pop),
      .buf_we    (buf_we),
      .buf_waddr (buf_waddr),
      .buf_wdata (buf_wdata),
      .count     (count),
      .nonempty  (nonempty)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: pending beats in a queue; an entry is formed when two are waiting
   // or the group ends. Occupancy is entries written minus entries popped.
   typedef struct {
      logic [31:0] instr;
      logic [1:0]  tag;
   } beat_t;

   beat_t       pend[$];
   int          m_count = 0;
   int          m_wptr  = 0;
   bit          m_we    = 0;
   logic [3:0]  m_waddr = '0;
   logic [67:0] m_wdata = '0;
   bit          model_on = 0;

   always @(posedge clk) begin
      bit    rdy;
      bit    new_we;
      beat_t b;
      beat_t first;
      beat_t second;
      if (reset || clear) begin
         m_count = 0;
         m_we    = 0;
         m_wptr  = 0;
         pend.delete();
         if (reset) begin
            m_waddr  = '0;
            m_wdata  = '0;
            model_on = 1;
         end
      end else begin
         rdy    = (m_count + int'(m_we)) < 16;
         new_we = 0;
         m_count = m_count + int'(m_we) - ((rd_pop && m_count > 0) ? 1 : 0);
         if (in_valid && rdy) begin
            b.instr = in_instr;
            b.tag   = in_tag;
            pend.push_back(b);
            if (pend.size() == 2 || in_last) begin
               first = pend[0];
               if (pend.size() == 2) second = pend[1];
               else begin
                  second.instr = UOP_NOP;
                  second.tag   = 2'd0;
               end
               m_wdata = {first.tag, second.tag, second.instr, first.instr};
               m_waddr = 4'(m_wptr);
               m_wptr  = (m_wptr + 1) % 16;
               pend.delete();
               new_we = 1;
            end
         end
         m_we = new_we;
      end
   end

   always @(negedge clk) begin
      if (model_on) begin
         check("m_buf_we", 68'(buf_we), 68'(m_we));
         check("m_count", 68'(count), 68'(m_count));
         check("m_nonempty", 68'(nonempty), 68'(m_count != 0));
         check("m_in_ready", 68'(in_ready), 68'((m_count + int'(m_we)) < 16));
         if (m_we) begin
            check("m_buf_waddr", 68'(buf_waddr), 68'(m_waddr));
            check("m_buf_wdata", buf_wdata, m_wdata);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [31:0] instr, input logic [1:0] tag, input logic last);
      bit done;
      in_valid = 1'b1;
      in_instr = instr;
      in_tag   = tag;
      in_last  = last;
      done     = 0;
      for (int i = 0; i < 64 && !done; i++) begin
         if (in_ready) done = 1;
         tick();
      end
      if (!done) begin
         check("beat_timeout", 68'(0), 68'(1));
      end
   endtask

   task automatic idle();
      in_valid = 1'b0;
      in_last  = 1'b0;
      tick();
   endtask

   initial begin
      reset    = 1'b1;
      clear    = 1'b0;
      in_valid = 1'b0;
      in_instr = '0;
      in_tag   = '0;
      in_last  = 1'b0;
      rd_pop   = 1'b0;
      tick();
      tick();
      check("rst_buf_we", 68'(buf_we), 68'(0));
      check("rst_waddr", 68'(buf_waddr), 68'(0));
      check("rst_wdata", buf_wdata, 68'(0));
      check("rst_count", 68'(count), 68'(0));
      check("rst_nonempty", 68'(nonempty), 68'(0));
      reset = 1'b0;

      // Pair packing
      beat(32'hAAAA0001, 2'd1, 1'b0);
      beat(32'hBBBB0002, 2'd2, 1'b0);
      in_valid = 1'b0;
      check("pair_we", 68'(buf_we), 68'(1));
      check("pair_waddr", 68'(buf_waddr), 68'(0));
      check("pair_wdata", buf_wdata, {2'd1, 2'd2, 32'hBBBB0002, 32'hAAAA0001});
      check("pair_count_before", 68'(count), 68'(0));
      idle();
      check("pair_count_after", 68'(count), 68'(1));
      check("pair_nonempty", 68'(nonempty), 68'(1));

      // Group close in EMPTY, then a last-beat in HALF
      beat(32'h12345678, 2'd3, 1'b1);
      in_valid = 1'b0;
      check("close_wdata", buf_wdata, {2'd3, 2'd0, 32'h0000_0000, 32'h12345678});
      check("close_waddr", 68'(buf_waddr), 68'(1));
      beat(32'hCAFE0001, 2'd1, 1'b0);
      beat(32'hCAFE0002, 2'd2, 1'b1);
      in_valid = 1'b0;
      check("half_last_wdata", buf_wdata, {2'd1, 2'd2, 32'hCAFE0002, 32'hCAFE0001});
      check("half_last_waddr", 68'(buf_waddr), 68'(2));

      // Write and pop on the same edge, then pop at empty
      beat(32'h0000_0A01, 2'd0, 1'b0);
      beat(32'h0000_0A02, 2'd1, 1'b0);
      in_valid = 1'b0;
      check("sim_count_pre", 68'(count), 68'(3));
      rd_pop = 1'b1;
      tick();
      check("sim_count_same", 68'(count), 68'(3));
      tick();
      tick();
      tick();
      check("drain_count", 68'(count), 68'(0));
      tick();
      check("underflow_count", 68'(count), 68'(0));
      rd_pop = 1'b0;

      // Clear mid-pair with count=5
      for (int i = 0; i < 10; i++) beat(32'h2000_0000 + 32'(i), 2'(i), 1'b0);
      idle();
      check("pre_clear_count", 68'(count), 68'(5));
      beat(32'h3000_0001, 2'd1, 1'b0);
      clear    = 1'b1;
      in_valid = 1'b1;
      in_instr = 32'h3000_0002;
      in_tag   = 2'd2;
      tick();
      clear    = 1'b0;
      in_valid = 1'b0;
      check("clear_count", 68'(count), 68'(0));
      check("clear_we", 68'(buf_we), 68'(0));
      beat(32'h4000_0001, 2'd3, 1'b0);
      beat(32'h4000_0002, 2'd0, 1'b0);
      in_valid = 1'b0;
      check("post_clear_waddr", 68'(buf_waddr), 68'(0));
      check("post_clear_wdata", buf_wdata, {2'd3, 2'd0, 32'h4000_0002, 32'h4000_0001});

      // Full and wrap
      clear = 1'b1;
      tick();
      clear = 1'b0;
      for (int i = 0; i < 32; i++) beat(32'h1000_0000 + 32'(i), 2'(i % 4), 1'b0);
      idle();
      idle();
      check("full_count", 68'(count), 68'(16));
      check("full_ready", 68'(in_ready), 68'(0));
      rd_pop = 1'b1;
      tick();
      rd_pop = 1'b0;
      check("pop_ready", 68'(in_ready), 68'(1));
      beat(32'h5000_0001, 2'd1, 1'b0);
      beat(32'h5000_0002, 2'd3, 1'b0);
      in_valid = 1'b0;
      check("wrap_waddr", 68'(buf_waddr), 68'(0));
      check("wrap_wdata", buf_wdata, {2'd1, 2'd3, 32'h5000_0002, 32'h5000_0001});
      idle();
      check("wrap_count", 68'(count), 68'(16));

      // Reset in the cycle buf_we=1, then reset discarding a held instruction
      clear = 1'b1;
      tick();
      clear = 1'b0;
      beat(32'h6000_0001, 2'd1, 1'b0);
      beat(32'h6000_0002, 2'd2, 1'b0);
      check("rst_we_pre", 68'(buf_we), 68'(1));
      reset    = 1'b1;
      in_instr = 32'h6000_0003;
      tick();
      reset    = 1'b0;
      in_valid = 1'b0;
      check("rst_we_count", 68'(count), 68'(0));
      check("rst_we_we", 68'(buf_we), 68'(0));
      beat(32'h7000_0001, 2'd2, 1'b0);
      in_valid = 1'b0;
      reset    = 1'b1;
      tick();
      reset = 1'b0;
      beat(32'h7000_0002, 2'd1, 1'b1);
      in_valid = 1'b0;
      check("rst_hold_wdata", buf_wdata, {2'd1, 2'd0, 32'h0000_0000, 32'h7000_0002});
      check("rst_hold_waddr", 68'(buf_waddr), 68'(0));
      idle();
      idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
